pcie_dll_tx_replay: RTL and testbench

PCIE_DLL_TX_REPLAY -- requirements
Module: pcie_dll_tx_replay

---
 rtl/pcie_dll_tx_replay.sv | 170 +++++++++++++++++
 tb/tb_pcie_dll_tx_replay.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dll_tx_replay.sv
// PCIe data-link-layer transmit side: sequence numbering, replay buffer,
// Ack/Nak purge, replay timer and retransmission state machine.
module pcie_dll_tx_replay #(
  parameter int unsigned TLP_W          = 224,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned REPLAY_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tlp_valid_i,
  input  logic [TLP_W-1:0]           tlp_i,
  output logic                       tlp_ready_o,
  output logic                       tlp_valid_o,
  output logic [TLP_W+15:0]          tlp_o,
  input  logic                       tlp_ready_i,
  input  logic                       dllp_valid_i,
  input  logic                       dllp_is_nak_i,
  input  logic [11:0]                dllp_seq_i,
  input  logic                       tlp_blocking_i,
  output logic                       replay_active_o,
  output logic                       retrain_req_o,
  output logic [$clog2(DEPTH):0]     buf_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(REPLAY_TIMEOUT + 1);
  localparam int unsigned EW = TLP_W + 12;

  typedef enum logic {NORMAL, REPLAY} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   buf_mem [DEPTH];
  logic [11:0]     next_seq_q, ackd_seq_q;
  // Pointers carry one extra bit so an offset of exactly DEPTH is unambiguous.
  logic [AW:0]     wr_ptr_q, rd_ptr_q, rp_ptr_q, count_q;
  logic [TW-1:0]   timer_q;
  logic [1:0]      replay_num_q;
  logic            pending_q;

  logic            out_free, accept;
  logic [11:0]     n_full;
  logic            dllp_ok, purge_any, nak_pend, timeout;
  logic [AW:0]     purge_n, rd_ptr_d, count_d, rp_off, rp_eff;
  logic            replay_start, load_replay;

  assign out_free    = !tlp_valid_o || tlp_ready_i;
  assign tlp_ready_o = (state_q == NORMAL) && !pending_q && (count_q < (AW+1)'(DEPTH)) &&
                       !tlp_blocking_i && out_free;
  assign accept      = tlp_valid_i && tlp_ready_o;

  // DLLPs acknowledging more than is outstanding are dropped without effect.
  assign n_full    = dllp_seq_i - ackd_seq_q;
  assign dllp_ok   = dllp_valid_i && (n_full <= 12'(count_q));
  assign purge_n   = dllp_ok ? n_full[AW:0] : '0;
  assign purge_any = dllp_ok && (n_full != 12'd0);
  assign rd_ptr_d  = rd_ptr_q + purge_n;
  assign count_d   = count_q + (AW+1)'(accept) - purge_n;

  // A purge that overtakes the replay cursor drags the cursor along with it.
  assign rp_off = rp_ptr_q - rd_ptr_q;
  assign rp_eff = (purge_n > rp_off) ? rd_ptr_d : rp_ptr_q;

  assign nak_pend = dllp_ok && dllp_is_nak_i && (state_q == NORMAL) && (count_d != '0);
  assign timeout  = (state_q == NORMAL) && (timer_q == TW'(REPLAY_TIMEOUT)) && !purge_any;

  assign replay_active_o = (state_q == REPLAY);
  assign buf_count_o     = count_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NORMAL;
    else        state_q <= state_d;
  end

  // Next state plus replay start / replay fetch strobes
  always_comb begin
    state_d      = state_q;
    replay_start = 1'b0;
    load_replay  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (pending_q && out_free) begin
          replay_start = 1'b1;
          state_d      = REPLAY;
        end
      end
      REPLAY: begin
        if (out_free) begin
          if (rp_eff != wr_ptr_q) load_replay = 1'b1;
          else                    state_d     = NORMAL;
        end
      end
    endcase
  end

  // Replay buffer storage; contents are meaningful only between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_ptr_q[AW-1:0]] <= {next_seq_q, tlp_i};
  end

  // Output register: new TLPs have priority, replay entries fill otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_valid_o <= 1'b0;
      tlp_o       <= '0;
    end else if (out_free) begin
      if (accept) begin
        tlp_valid_o <= 1'b1;
        tlp_o       <= {4'h0, next_seq_q, tlp_i};
      end else if (load_replay) begin
        tlp_valid_o <= 1'b1;
        tlp_o       <= {4'h0, buf_mem[rp_eff[AW-1:0]]};
      end else begin
        tlp_valid_o <= 1'b0;
      end
    end
  end

  // Sequence counters, buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_seq_q <= '0;
      ackd_seq_q <= 12'hFFF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rp_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (accept)  next_seq_q <= next_seq_q + 12'd1;
      if (dllp_ok) ackd_seq_q <= dllp_seq_i;
      wr_ptr_q <= wr_ptr_q + (AW+1)'(accept);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (replay_start)           rp_ptr_q <= rd_ptr_d;
      else if (state_q == REPLAY) rp_ptr_q <= rp_eff + (AW+1)'(load_replay);
    end
  end

  // Replay timer and pending-replay flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (replay_start || purge_any || (count_q == '0))
        timer_q <= '0;
      else if ((state_q == NORMAL) && (timer_q != TW'(REPLAY_TIMEOUT)))
        timer_q <= timer_q + 1'b1;
      if (replay_start)            pending_q <= 1'b0;
      else if (timeout || nak_pend) pending_q <= 1'b1;
    end
  end

  // Consecutive-replay counter and retrain pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_num_q  <= '0;
      retrain_req_o <= 1'b0;
    end else begin
      retrain_req_o <= 1'b0;
      if (replay_start) begin
        retrain_req_o <= (replay_num_q == 2'd3);
        replay_num_q  <= (replay_num_q == 2'd3) ? 2'd0 : replay_num_q + 2'd1;
      end else if (purge_any && !dllp_is_nak_i) begin
        replay_num_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dll_tx_replay.sv
// Directed bench for pcie_dll_tx_replay with small parameters.
module tb_pcie_dll_tx_replay;

  localparam int unsigned TLP_W = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tlp_valid_i;
  logic [TLP_W-1:0]  tlp_i;
  logic              tlp_ready_o;
  logic              tlp_valid_o;
  logic [TLP_W+15:0] tlp_o;
  logic              tlp_ready_i;
  logic              dllp_valid_i;
  logic              dllp_is_nak_i;
  logic [11:0]       dllp_seq_i;
  logic              tlp_blocking_i;
  logic              replay_active_o;
  logic              retrain_req_o;
  logic [3:0]        buf_count_o;

  int total = 0;
  int bad   = 0;

  pcie_dll_tx_replay #(.TLP_W(TLP_W), .DEPTH(DEPTH), .REPLAY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tlp_valid_i(tlp_valid_i), .tlp_i(tlp_i), .tlp_ready_o(tlp_ready_o),
    .tlp_valid_o(tlp_valid_o), .tlp_o(tlp_o), .tlp_ready_i(tlp_ready_i),
    .dllp_valid_i(dllp_valid_i), .dllp_is_nak_i(dllp_is_nak_i), .dllp_seq_i(dllp_seq_i),
    .tlp_blocking_i(tlp_blocking_i), .replay_active_o(replay_active_o),
    .retrain_req_o(retrain_req_o), .buf_count_o(buf_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fr(input int seq);
    logic [11:0] s;
    s = 12'(seq);
    return {20'h0, s, 32'hC0DE_0000 + 32'(seq)};
  endfunction

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic do_reset();
    tlp_valid_i = 0; tlp_i = '0; tlp_ready_i = 1; dllp_valid_i = 0;
    dllp_is_nak_i = 0; dllp_seq_i = '0; tlp_blocking_i = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic send_dllp(input logic nak, input logic [11:0] seq);
    dllp_valid_i = 1; dllp_is_nak_i = nak; dllp_seq_i = seq;
    tick();
    dllp_valid_i = 0; dllp_is_nak_i = 0;
  endtask

  int lat, nrep, pulses, rep_at;
  logic prev_act;

  initial begin
    // Reset values
    tlp_valid_i = 0; tlp_i = '0; tlp_ready_i = 1; dllp_valid_i = 0;
    dllp_is_nak_i = 0; dllp_seq_i = '0; tlp_blocking_i = 0;
    rst_n = 0;
    #12;
    chk("rst_valid", 64'(tlp_valid_o), 64'd0);
    chk("rst_tlp", 64'(tlp_o), 64'd0);
    chk("rst_count", 64'(buf_count_o), 64'd0);
    chk("rst_replay", 64'(replay_active_o), 64'd0);
    chk("rst_retrain", 64'(retrain_req_o), 64'd0);
    rst_n = 1;
    tick();
    chk("ready_after_rst", 64'(tlp_ready_o), 64'd1);

    // Three back-to-back TLPs framed with seq 0,1,2
    tlp_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      tlp_i = dat(i);
      tick();
      chk($sformatf("b2b_seq%0d", i), 64'(tlp_o), fr(i));
      chk($sformatf("b2b_vld%0d", i), 64'(tlp_valid_o), 64'd1);
    end
    tlp_valid_i = 0;
    chk("b2b_count", 64'(buf_count_o), 64'd3);

    // Buffer full after DEPTH accepts; Ack seq 3 frees four entries
    do_reset();
    tlp_valid_i = 1;
    for (int i = 0; i < 8; i++) begin
      tlp_i = dat(i);
      tick();
    end
    chk("full_last", 64'(tlp_o), fr(7));
    chk("full_count", 64'(buf_count_o), 64'd8);
    chk("full_ready", 64'(tlp_ready_o), 64'd0);
    tlp_i = dat(8);
    tick();
    chk("full_hold_count", 64'(buf_count_o), 64'd8);
    tlp_valid_i = 0;
    send_dllp(0, 12'd3);
    chk("ack3_count", 64'(buf_count_o), 64'd4);
    chk("ack3_ready", 64'(tlp_ready_o), 64'd1);

    // Backpressure hold, ignored Ack, Ack n=0, accept with same-cycle purge
    do_reset();
    tlp_ready_i = 0;
    tlp_valid_i = 1; tlp_i = dat(0);
    tick();
    chk("bp_first", 64'(tlp_o), fr(0));
    chk("bp_ready", 64'(tlp_ready_o), 64'd0);
    tick();
    chk("bp_hold", 64'(tlp_o), fr(0));
    chk("bp_count", 64'(buf_count_o), 64'd1);
    tlp_ready_i = 1; tlp_i = dat(1);
    tick();
    chk("bp_next", 64'(tlp_o), fr(1));
    chk("bp_count2", 64'(buf_count_o), 64'd2);
    tlp_valid_i = 0;
    send_dllp(0, 12'd100);
    chk("ack100_ignored", 64'(buf_count_o), 64'd2);
    send_dllp(0, 12'hFFF);
    chk("ack_n0", 64'(buf_count_o), 64'd2);
    tlp_valid_i = 1; tlp_i = dat(2);
    send_dllp(0, 12'd0);
    tlp_valid_i = 0;
    chk("acc_purge_count", 64'(buf_count_o), 64'd2);
    chk("acc_purge_tlp", 64'(tlp_o), fr(2));
    tlp_blocking_i = 1;
    #1;
    chk("blocked_ready", 64'(tlp_ready_o), 64'd0);
    tlp_blocking_i = 0;
    #1;
    chk("unblocked_ready", 64'(tlp_ready_o), 64'd1);

    // Nak seq 1 after seq 0..4: purge two, replay 2,3,4
    do_reset();
    tlp_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      tlp_i = dat(i);
      tick();
    end
    tlp_valid_i = 0;
    send_dllp(1, 12'd1);
    chk("nak_count", 64'(buf_count_o), 64'd3);
    tick();
    chk("nak_active", 64'(replay_active_o), 64'd1);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk($sformatf("replay_seq%0d", k), 64'(tlp_o), fr(k));
      chk($sformatf("replay_vld%0d", k), 64'(tlp_valid_o & replay_active_o), 64'd1);
    end
    tick();
    chk("replay_end_active", 64'(replay_active_o), 64'd0);
    chk("replay_end_count", 64'(buf_count_o), 64'd3);
    chk("replay_end_valid", 64'(tlp_valid_o), 64'd0);

    // Timeout-driven replays; fourth consecutive one requests retrain
    do_reset();
    tlp_valid_i = 1; tlp_i = dat(0);
    tick();
    tlp_valid_i = 0;
    lat = 0;
    while (!replay_active_o && lat < 40) begin
      tick();
      lat++;
    end
    chk("timeout_latency_ok", 64'((lat >= TMO && lat <= TMO + 3) ? 1 : 0), 64'd1);
    nrep = replay_active_o ? 1 : 0;
    pulses = 0; rep_at = 0; prev_act = replay_active_o;
    for (int c = 0; c < 200 && nrep < 4; c++) begin
      tick();
      if (replay_active_o && !prev_act) nrep++;
      if (retrain_req_o) begin
        pulses++;
        rep_at = nrep;
      end
      prev_act = replay_active_o;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (retrain_req_o) pulses++;
    end
    chk("replay_rounds", 64'(nrep), 64'd4);
    chk("retrain_pulses", 64'(pulses), 64'd1);
    chk("retrain_on_4th", 64'(rep_at), 64'd4);

    // Asynchronous reset in the middle of a replay
    do_reset();
    tlp_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      tlp_i = dat(i);
      tick();
    end
    tlp_valid_i = 0;
    send_dllp(1, 12'hFFF);
    tick();
    chk("mid_active", 64'(replay_active_o), 64'd1);
    tlp_ready_i = 0;
    tick();
    chk("mid_tlp", 64'(tlp_o), fr(0));
    rst_n = 0;
    #1;
    chk("arst_active", 64'(replay_active_o), 64'd0);
    chk("arst_valid", 64'(tlp_valid_o), 64'd0);
    chk("arst_tlp", 64'(tlp_o), 64'd0);
    chk("arst_count", 64'(buf_count_o), 64'd0);
    chk("arst_retrain", 64'(retrain_req_o), 64'd0);
    tick();
    rst_n = 1; tlp_ready_i = 1;
    tick();
    chk("post_rst_ready", 64'(tlp_ready_o), 64'd1);
    tlp_valid_i = 1; tlp_i = dat(0);
    tick();
    tlp_valid_i = 0;
    chk("post_rst_seq0", 64'(tlp_o), fr(0));
    chk("post_rst_count", 64'(buf_count_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
